// File: rtl/auth_responder_pkg.sv
// Package: auth_responder_pkg
// Purpose: shared state encoding and default parameter values for the
//          password verifier (auth_responder) and its lockout timer.
// Contents:
//   state_t        FSM state encoding (IDLE=0, CHECK=1, RESP=2, LOCKED=3)
//   DEF_PW_W       default password / guess width
//   DEF_RESET_PW   default password loaded at reset
// Optional feature macro: AUTH_LOCKOUT_EN (left undefined by default, so the
// default build has no lockout).
package auth_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_RESP   = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  localparam int         DEF_PW_W     = 4;
  localparam logic [3:0] DEF_RESET_PW = 4'hA;

endpackage

// File: rtl/auth_lock_timer.sv
// Module: auth_lock_timer
// Purpose: lockout down-counter. A load starts a run of exactly CYCLES
//          cycles; o_done is high in the last cycle of the run.
// Ports:
//   clk     in  clock, rising edge
//   rst_n   in  synchronous active-low reset
//   i_load  in  start a new run (count <= CYCLES-1)
//   o_done  out terminal count reached while running
// Only built when AUTH_LOCKOUT_EN is defined (see auth_responder).
module auth_lock_timer #(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_done
);

  localparam int TW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [TW-1:0] r_cnt;
  logic          r_busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_load) begin
      r_cnt  <= TW'(CYCLES - 1);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt - TW'(1);
      end
    end
  end

  assign o_done = r_busy && (r_cnt == '0);

endmodule

// File: rtl/auth_responder.sv
// Module: auth_responder
// Purpose: verifier end of the password protocol. Holds the password,
//          accepts guesses over a valid/ready channel, answers grant/deny
//          over a second valid/ready channel, counts consecutive denies
//          (saturating) and optionally locks the guess channel for a fixed
//          time after too many denies.
// Ports:
//   clk, rst_n                     clock; synchronous active-low reset
//   set_valid, set_pw              load a new password (honoured in IDLE only)
//   guess_valid, guess_ready,
//   guess_pw                       guess channel
//   resp_valid, resp_ready,
//   resp_grant                     response channel
//   fail_cnt                       consecutive deny count, saturates at MAX_FAILS
//   locked                         lockout active
// Optional feature: define AUTH_LOCKOUT_EN to build the LOCKED state and the
// lockout timer; without it locked is tied low and RESP always returns to IDLE.
//
// state  | meaning
// IDLE   | waiting for a guess; password may be rewritten (set beats guess)
// CHECK  | one cycle: compare captured guess with password, update fail_cnt
// RESP   | response held until resp_ready
// LOCKED | guess channel closed for LOCK_CYCLES cycles
module auth_responder
  import auth_responder_pkg::*;
#(
  parameter int              PW_W        = DEF_PW_W,
  parameter logic [PW_W-1:0] RESET_PW    = PW_W'(DEF_RESET_PW),
  parameter int              MAX_FAILS   = 3,
  parameter int              LOCK_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           set_valid,
  input  logic [PW_W-1:0]                set_pw,
  input  logic                           guess_valid,
  output logic                           guess_ready,
  input  logic [PW_W-1:0]                guess_pw,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic                           resp_grant,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt,
  output logic                           locked
);

  localparam int FW = $clog2(MAX_FAILS + 1);

  // Out-of-range parameters are rejected at elaboration.
  if (MAX_FAILS < 1 || LOCK_CYCLES < 1) begin : g_param_err
    $error("auth_responder: MAX_FAILS and LOCK_CYCLES must be >= 1");
  end

  state_t          r_state, w_state_nxt;
  logic [PW_W-1:0] r_pw, w_pw_nxt;
  logic [PW_W-1:0] r_guess, w_guess_nxt;
  logic [FW-1:0]   r_fail_cnt, w_fail_nxt;
  logic            r_resp_valid, w_resp_valid_nxt;
  logic            r_resp_grant, w_resp_grant_nxt;
  logic            w_match;
  logic            w_fail_max;

`ifdef AUTH_LOCKOUT_EN
  logic r_locked, w_locked_nxt;
  logic w_timer_load;
  logic w_timer_done;

  auth_lock_timer #(
    .CYCLES (LOCK_CYCLES)
  ) u_lock_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_timer_load),
    .o_done (w_timer_done)
  );

  assign locked = r_locked;
`else
  assign locked = 1'b0;
`endif

  // Password cannot change outside IDLE, so r_pw in CHECK is the value
  // in force when the guess was accepted (or set just before it).
  assign w_match     = (r_guess == r_pw);
  assign w_fail_max  = (r_fail_cnt == FW'(MAX_FAILS));
  assign guess_ready = (r_state == ST_IDLE) && !set_valid;

  always_comb begin
    w_state_nxt      = r_state;
    w_pw_nxt         = r_pw;
    w_guess_nxt      = r_guess;
    w_fail_nxt       = r_fail_cnt;
    w_resp_valid_nxt = r_resp_valid;
    w_resp_grant_nxt = r_resp_grant;
`ifdef AUTH_LOCKOUT_EN
    w_locked_nxt     = r_locked;
    w_timer_load     = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (set_valid) begin
          w_pw_nxt = set_pw;
        end else if (guess_valid) begin
          w_guess_nxt = guess_pw;
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (w_match) begin
          w_fail_nxt = '0;
        end else if (!w_fail_max) begin
          w_fail_nxt = r_fail_cnt + FW'(1);
        end
        w_resp_valid_nxt = 1'b1;
        w_resp_grant_nxt = w_match;
        w_state_nxt      = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          w_resp_valid_nxt = 1'b0;
          w_state_nxt      = ST_IDLE;
`ifdef AUTH_LOCKOUT_EN
          // fail_cnt already reflects this response's deny.
          if (w_fail_max) begin
            w_state_nxt  = ST_LOCKED;
            w_timer_load = 1'b1;
            w_locked_nxt = 1'b1;
          end
`endif
        end
      end
      ST_LOCKED: begin
`ifdef AUTH_LOCKOUT_EN
        if (w_timer_done) begin
          w_state_nxt  = ST_IDLE;
          w_locked_nxt = 1'b0;
          w_fail_nxt   = '0;
        end
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_pw         <= RESET_PW;
      r_guess      <= '0;
      r_fail_cnt   <= '0;
      r_resp_valid <= 1'b0;
      r_resp_grant <= 1'b0;
`ifdef AUTH_LOCKOUT_EN
      r_locked     <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_pw         <= w_pw_nxt;
      r_guess      <= w_guess_nxt;
      r_fail_cnt   <= w_fail_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_grant <= w_resp_grant_nxt;
`ifdef AUTH_LOCKOUT_EN
      r_locked     <= w_locked_nxt;
`endif
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_grant = r_resp_grant;
  assign fail_cnt   = r_fail_cnt;

endmodule
